// File: rtl/rsa_pkg.sv
// Shared constants, state encoding and helpers for the RSA256 byte-stream wrapper.
package rsa_pkg;

    localparam int KEY_BITS_DEF = 256;
    localparam int CNT_W        = 6;

    typedef logic [2:0] state_t;

    localparam state_t S_GET_N    = 3'd0;
    localparam state_t S_GET_D    = 3'd1;
    localparam state_t S_GET_A    = 3'd2;
    localparam state_t S_CORE_RST = 3'd3;
    localparam state_t S_START    = 3'd4;
    localparam state_t S_WAIT     = 3'd5;
    localparam state_t S_SEND     = 3'd6;

    // True for the states that take operand bytes from the receive stream
    function automatic logic is_rx_state(input state_t s);
        return (s == S_GET_N) || (s == S_GET_D) || (s == S_GET_A);
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Wide register that can be parallel-loaded or shifted left by one byte per cycle.
module byte_shift_reg #(
    parameter int WIDTH = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Load wins over shift; a shift pushes the new byte in at the bottom
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_value_i;
        end else if (shift_i) begin
            value_d = {value_q[WIDTH-9:0], byte_i};
        end
    end

    // Register with asynchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/rsa_stream_wrapper.sv
// Byte-stream front end for the RSA256 decryption core.
// Collects N, d and ciphertext blocks MSB byte first, runs the core, and
// returns the low KEY_BITS/8-1 bytes of each plaintext block.
// Optional build macro RSA_KEY_RELOAD_EN adds i_key_reload, which makes the
// wrapper accept a fresh N and d after the current block completes.
module rsa_stream_wrapper
    import rsa_pkg::*;
#(
    parameter int KEY_BITS = KEY_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
`ifdef RSA_KEY_RELOAD_EN
    input  logic                i_key_reload,
`endif
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_rx_ready,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_core_rst,
    output logic                o_core_start,
    output logic [KEY_BITS-1:0] o_core_n,
    output logic [KEY_BITS-1:0] o_core_d,
    output logic [KEY_BITS-1:0] o_core_a,
    input  logic [KEY_BITS-1:0] i_core_result,
    input  logic                i_core_finished
);

    localparam int IN_BYTES  = KEY_BITS / 8;
    localparam int OUT_BYTES = IN_BYTES - 1;
    localparam int TX_BITS   = KEY_BITS - 8;

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BYTES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               rx_ready_q;

    logic               rx_fire;
    logic               tx_fire;
    logic               n_shift;
    logic               d_shift;
    logic               a_shift;
    logic               tx_load;
    logic               tx_shift;
    logic [TX_BITS-1:0] tx_value;
    logic [7:0]         unused_result_top;

`ifdef RSA_KEY_RELOAD_EN
    logic               reload_q;
    logic               reload_take;
`endif

    // The top result byte is never transmitted, so it is not stored
    assign unused_result_top = i_core_result[KEY_BITS-1 -: 8];

    assign rx_fire = rx_ready_q && i_rx_valid;
    assign tx_fire = (state_q == S_SEND) && i_tx_ready;

    byte_shift_reg #(.WIDTH(KEY_BITS)) u_n_reg (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (1'b0),
        .load_value_i ('0),
        .shift_i      (n_shift),
        .byte_i       (i_rx_data),
        .value_o      (o_core_n)
    );

    byte_shift_reg #(.WIDTH(KEY_BITS)) u_d_reg (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (1'b0),
        .load_value_i ('0),
        .shift_i      (d_shift),
        .byte_i       (i_rx_data),
        .value_o      (o_core_d)
    );

    byte_shift_reg #(.WIDTH(KEY_BITS)) u_a_reg (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (1'b0),
        .load_value_i ('0),
        .shift_i      (a_shift),
        .byte_i       (i_rx_data),
        .value_o      (o_core_a)
    );

    byte_shift_reg #(.WIDTH(TX_BITS)) u_tx_reg (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (tx_load),
        .load_value_i (i_core_result[TX_BITS-1:0]),
        .shift_i      (tx_shift),
        .byte_i       (8'h00),
        .value_o      (tx_value)
    );

    // Next-state, byte-counter and shift-enable decode for the block sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_shift  = 1'b0;
        d_shift  = 1'b0;
        a_shift  = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
`ifdef RSA_KEY_RELOAD_EN
        reload_take = 1'b0;
`endif
        case (state_q)
            S_GET_N: begin
                if (rx_fire) begin
                    n_shift = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        state_d = S_GET_D;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GET_D: begin
                if (rx_fire) begin
                    d_shift = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        state_d = S_GET_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_GET_A: begin
`ifdef RSA_KEY_RELOAD_EN
                if (reload_q && (cnt_q == '0)) begin
                    reload_take = 1'b1;
                    state_d     = S_GET_N;
                    if (rx_fire) begin
                        n_shift = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end else
`endif
                if (rx_fire) begin
                    a_shift = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        state_d = S_CORE_RST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CORE_RST: begin
                state_d = S_START;
                cnt_d   = '0;
            end
            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (i_core_finished) begin
                    tx_load = 1'b1;
                    state_d = S_SEND;
                    cnt_d   = '0;
                end
            end
            S_SEND: begin
                if (tx_fire) begin
                    tx_shift = 1'b1;
                    if (cnt_q == OUT_LAST) begin
                        state_d = S_GET_A;
                        cnt_d   = '0;
`ifdef RSA_KEY_RELOAD_EN
                        if (reload_q) begin
                            reload_take = 1'b1;
                            state_d     = S_GET_N;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_GET_N;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered receive-ready; ready follows the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_GET_N;
            cnt_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= is_rx_state(state_d);
        end
    end

`ifdef RSA_KEY_RELOAD_EN
    // Sticky key-reload request, consumed when the sequencer returns to S_GET_N
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= (reload_q && !reload_take) || i_key_reload;
        end
    end
`endif

    assign o_rx_ready   = rx_ready_q;
    assign o_tx_valid   = (state_q == S_SEND);
    assign o_tx_data    = tx_value[TX_BITS-1 -: 8];
    assign o_core_rst   = (state_q == S_CORE_RST);
    assign o_core_start = (state_q == S_START);

endmodule
